// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N_CH independent leaky integrate-and-fire neurons sharing a
// run-time threshold, with refractory period, selectable post-spike reset and a
// saturating 16-bit count of all spikes produced.
module lif_neuron_array #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC_CYC = 2,
  parameter int RESET_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_CH*WIDTH-1:0]  current,
  input  logic [WIDTH-1:0]       threshold,
  input  logic                   clr_cnt,
  output logic [N_CH-1:0]        spike,
  output logic [N_CH*WIDTH-1:0]  state,
  output logic [N_CH-1:0]        refractory,
  output logic [15:0]            spike_total
);

  // Counter wide enough to hold REFRAC_CYC; one bit minimum so REFRAC_CYC=0 still builds.
  localparam int CW = (REFRAC_CYC < 1) ? 1 : $clog2(REFRAC_CYC + 1);
  localparam logic [CW-1:0] REFRAC_LD = CW'(REFRAC_CYC);
  // Popcount width: holds values 0..N_CH.
  localparam int PW = $clog2(N_CH + 1);

  // Clamp the WIDTH+1 bit integration sum to the largest representable potential.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] s);
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // Add this edge's spike count to the running total, sticking at 16'hFFFF.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [PW-1:0] b);
    logic [16:0] t;
    t = {1'b0, a} + 17'(b);
    return t[16] ? 16'hFFFF : t[15:0];
  endfunction

  logic [WIDTH-1:0] r_v       [N_CH];
  logic [CW-1:0]    r_cnt     [N_CH];
  logic [N_CH-1:0]  r_spike;
  logic [N_CH-1:0]  r_refrac;
  logic [15:0]      r_total;

  logic [WIDTH-1:0] w_v_nxt   [N_CH];
  logic [CW-1:0]    w_cnt_nxt [N_CH];
  logic [N_CH-1:0]  w_spike_nxt;
  logic [N_CH-1:0]  w_refrac_nxt;
  logic [PW-1:0]    w_pop;

  // Per-channel integration step: leak, add current, saturate, compare, fire/reset.
  always_comb begin
    logic [WIDTH-1:0] sum;
    w_spike_nxt  = '0;
    w_refrac_nxt = '0;
    w_pop        = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_v_nxt[k]   = r_v[k];
      w_cnt_nxt[k] = r_cnt[k];
      sum = sat_sum({1'b0, current[k*WIDTH +: WIDTH]} + {1'b0, (r_v[k] >> LEAK_SHIFT)});
      if (en) begin
        if (r_cnt[k] != '0) begin
          // Refractory: input ignored, potential held, counter runs down.
          w_cnt_nxt[k] = r_cnt[k] - CW'(1);
        end else if (sum >= threshold) begin
          w_spike_nxt[k] = 1'b1;
          w_cnt_nxt[k]   = REFRAC_LD;
          w_v_nxt[k]     = (RESET_MODE != 0) ? (sum - threshold) : '0;
        end else begin
          w_v_nxt[k] = sum;
        end
      end
      w_refrac_nxt[k] = (w_cnt_nxt[k] != '0);
      w_pop = w_pop + PW'(w_spike_nxt[k]);
    end
  end

  // Register neuron state, spikes, refractory flags and the spike total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]   <= '0;
        r_cnt[k] <= '0;
      end
      r_spike  <= '0;
      r_refrac <= '0;
      r_total  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]   <= w_v_nxt[k];
        r_cnt[k] <= w_cnt_nxt[k];
      end
      r_spike  <= w_spike_nxt;
      r_refrac <= w_refrac_nxt;
      // A clear wins over spikes produced on the same edge.
      r_total  <= clr_cnt ? 16'h0000 : sat_add16(r_total, w_pop);
    end
  end

  // Pack per-channel potentials onto the flat state bus.
  always_comb begin
    state = '0;
    for (int k = 0; k < N_CH; k++) state[k*WIDTH +: WIDTH] = r_v[k];
  end

  assign spike       = r_spike;
  assign refractory  = r_refrac;
  assign spike_total = r_total;

endmodule
